adc_scan_ctrl: RTL
==================

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of analog mux channels scanned (2..16).
REQ-002 SHALL have parameter CH_BITS, default 2, meaning width of channel index (clog2 NUM_CH).
REQ-003 SHALL have parameter ADC_WIDTH, default 8, meaning converter result width.
REQ-004 SHALL have parameter SETTLE_CYC, default 16, meaning clk cycles waited after a mux change (1..255).
REQ-005 SHALL have parameter DISCARD, default 2, meaning sample_rdy pulses dropped after settle (0..7) to flush the averager.
REQ-006 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-007 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle scan request.
REQ-009 SHALL have port abort  input  1  terminate scan, return to IDLE.
REQ-010 SHALL have port continuous  input  1  restart scan automatically after last channel.
REQ-011 SHALL have port ch_enable  input  NUM_CH  per-channel enable mask.
REQ-012 SHALL have port sample_rdy  input  1  converter result-valid pulse.
REQ-013 SHALL have port digital_in  input  ADC_WIDTH  converter result, valid with sample_rdy.
REQ-014 SHALL have port mux_sel  output  CH_BITS  analog mux select.
REQ-015 SHALL have port result_data  output  ADC_WIDTH  captured result.
REQ-016 SHALL have port result_ch  output  CH_BITS  channel of result_data.
REQ-017 SHALL have port result_valid  output  1  result handshake valid.
REQ-018 SHALL have port result_ready  input  1  consumer accepts result.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.
REQ-020 SHALL have port scan_done  output  1  one-cycle pulse after last enabled channel of a pass is accepted.

Function
REQ-021 SHALL implement states IDLE, SWITCH, DISCARD, CAPTURE, OUTPUT, NEXT.
REQ-022 IDLE: start=1 with nonzero ch_enable SHALL latch ch_enable into an internal mask, set mux_sel to lowest enabled index, go SWITCH; start with ch_enable=0 SHALL be ignored.
REQ-023 start while busy=1 SHALL be ignored; ch_enable changes while busy SHALL have no effect until next start.
REQ-024 SWITCH: SHALL count SETTLE_CYC cycles from entry, then go DISCARD (or CAPTURE if DISCARD=0); sample_rdy ignored in SWITCH.
REQ-025 DISCARD: SHALL count sample_rdy pulses, go CAPTURE in the cycle after the DISCARD-th pulse.
REQ-026 CAPTURE: on sample_rdy SHALL register digital_in into result_data, mux_sel into result_ch, and assert result_valid next cycle (state OUTPUT).
REQ-027 OUTPUT: result_valid, result_data, result_ch SHALL hold stable until a cycle with result_ready=1; that cycle completes the transfer and state goes NEXT; sample_rdy in OUTPUT SHALL be dropped.
REQ-028 NEXT (one cycle): SHALL select the next higher enabled index in the latched mask and go SWITCH; if none remains SHALL pulse scan_done and go SWITCH at lowest enabled index when continuous=1, else IDLE.
REQ-029 continuous SHALL be sampled only in NEXT.
REQ-030 Single enabled channel SHALL still pass through SWITCH each pass (re-settle).
REQ-031 abort=1 in any state SHALL force IDLE on next edge, clearing result_valid and counters; abort has priority over start and result_ready in the same cycle.
REQ-032 mux_sel SHALL change only on entry to SWITCH, never during DISCARD/CAPTURE/OUTPUT.
REQ-033 Settle counter SHALL be 8 bits, discard counter 3 bits; neither SHALL wrap.
REQ-034 Minimum latency start -> result_valid SHALL be 1 + SETTLE_CYC + (DISCARD+1) sample periods + 1 cycles.

Reset
REQ-035 rstn=0 SHALL asynchronously force IDLE, mux_sel=0, result_data=0, result_ch=0, result_valid=0, busy=0, scan_done=0, all counters and mask to 0.
REQ-036 Reset deassertion mid-scan SHALL resume in IDLE; no result from the interrupted scan SHALL appear.

Verification
REQ-037 ch_enable=4'b1010, continuous=0, start, result_ready=1, sample model returns 8'h40+ch -> results (ch1,8'h41),(ch3,8'h43), scan_done one pulse, busy low after.
REQ-038 ch_enable=4'b0000, start -> busy stays 0, no mux_sel change, no result_valid.
REQ-039 ch_enable=4'b0001, result_ready held 0 for 50 cycles over 3 sample_rdy pulses -> result_valid/data stable, later samples dropped, single transfer on ready.
REQ-040 continuous=1, ch_enable=4'b0011 -> results ch0,ch1,ch0,ch1, scan_done after each ch1 accept; drop continuous -> IDLE after next ch1.
REQ-041 abort asserted in DISCARD, and separately in OUTPUT with result_ready=1 same cycle -> IDLE next cycle, result_valid=0, no transfer counted.
REQ-042 rstn pulsed low mid-SWITCH -> all outputs zero immediately; after release new start scans from lowest enabled channel with full SETTLE_CYC.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_ctrl
// Description : Multi-channel ADC scan sequencer. It steps an analog mux
//               through a latched channel-enable mask. After each mux change
//               it waits for the input to settle and drops a number of
//               converter samples. It then captures one result per channel
//               and hands the result off with a valid/ready handshake.
//               Passes can repeat automatically in continuous mode.
// Ports       : clk, rstn             - clock, async active-low reset
//               start, abort          - scan request / forced return to idle
//               continuous            - auto-restart after the last channel
//               ch_enable             - per-channel enable, latched on start
//               sample_rdy/digital_in - converter result stream
//               mux_sel               - analog mux select
//               result_data/result_ch - captured sample and its channel
//               result_valid/_ready   - result handshake
//               busy, scan_done       - status, end-of-pass pulse
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int CH_BITS    = 2,
    parameter int ADC_WIDTH  = 8,
    parameter int SETTLE_CYC = 16,
    parameter int DISCARD    = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 continuous,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic                 sample_rdy,
    input  logic [ADC_WIDTH-1:0] digital_in,
    output logic [CH_BITS-1:0]   mux_sel,
    output logic [ADC_WIDTH-1:0] result_data,
    output logic [CH_BITS-1:0]   result_ch,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy,
    output logic                 scan_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SWITCH  = 3'd1,
        ST_DISCARD = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUTPUT  = 3'd4,
        ST_NEXT    = 3'd5
    } state_t;

    localparam logic [7:0] c_SETTLE_LAST  = 8'(SETTLE_CYC - 1);
    localparam logic [2:0] c_DISCARD_LAST = (DISCARD > 0) ? 3'(DISCARD - 1) : 3'd0;
    // With no samples to drop, settling leads straight to capture.
    localparam state_t     c_POST_SETTLE  = (DISCARD > 0) ? ST_DISCARD : ST_CAPTURE;

    state_t                 r_state;
    logic [NUM_CH-1:0]      r_mask;
    logic [7:0]             r_settle_cnt;
    logic [2:0]             r_discard_cnt;
    logic [CH_BITS-1:0]     r_mux_sel;
    logic [ADC_WIDTH-1:0]   r_result_data;
    logic [CH_BITS-1:0]     r_result_ch;
    logic                   r_result_valid;
    logic                   r_busy;
    logic                   r_scan_done;

    logic [CH_BITS-1:0]     w_next_idx;
    logic                   w_next_found;

    // Lowest set bit of a channel mask. The loop runs downward, so the
    // last hit it records is the lowest index.
    function automatic logic [CH_BITS-1:0] f_lowest(input logic [NUM_CH-1:0] m);
        logic [CH_BITS-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = CH_BITS'(i);
            end
        end
        return idx;
    endfunction

    // Nearest enabled channel strictly above the current mux selection.
    always_comb begin
        w_next_idx   = '0;
        w_next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_mux_sel))) begin
                w_next_idx   = CH_BITS'(i);
                w_next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= ST_IDLE;
            r_mask         <= '0;
            r_settle_cnt   <= 8'd0;
            r_discard_cnt  <= 3'd0;
            r_mux_sel      <= '0;
            r_result_data  <= '0;
            r_result_ch    <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_scan_done    <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            if (abort) begin
                // Abort overrides start and result_ready arriving in the same cycle.
                r_state        <= ST_IDLE;
                r_settle_cnt   <= 8'd0;
                r_discard_cnt  <= 3'd0;
                r_result_valid <= 1'b0;
                r_busy         <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && (|ch_enable)) begin
                            r_mask       <= ch_enable;
                            r_mux_sel    <= f_lowest(ch_enable);
                            r_settle_cnt <= 8'd0;
                            r_state      <= ST_SWITCH;
                            r_busy       <= 1'b1;
                        end
                    end
                    ST_SWITCH: begin
                        // The counter starts at zero on entry, so the state lasts exactly SETTLE_CYC cycles.
                        if (r_settle_cnt == c_SETTLE_LAST) begin
                            r_settle_cnt  <= 8'd0;
                            r_discard_cnt <= 3'd0;
                            r_state       <= c_POST_SETTLE;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 8'd1;
                        end
                    end
                    ST_DISCARD: begin
                        if (sample_rdy) begin
                            if (r_discard_cnt == c_DISCARD_LAST) begin
                                r_discard_cnt <= 3'd0;
                                r_state       <= ST_CAPTURE;
                            end else begin
                                r_discard_cnt <= r_discard_cnt + 3'd1;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (sample_rdy) begin
                            r_result_data  <= digital_in;
                            r_result_ch    <= r_mux_sel;
                            r_result_valid <= 1'b1;
                            r_state        <= ST_OUTPUT;
                        end
                    end
                    ST_OUTPUT: begin
                        if (result_ready) begin
                            r_result_valid <= 1'b0;
                            r_state        <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        r_settle_cnt <= 8'd0;
                        if (w_next_found) begin
                            r_mux_sel <= w_next_idx;
                            r_state   <= ST_SWITCH;
                        end else begin
                            r_scan_done <= 1'b1;
                            if (continuous) begin
                                // A single-channel mask re-enters SWITCH too, forcing a fresh settle.
                                r_mux_sel <= f_lowest(r_mask);
                                r_state   <= ST_SWITCH;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mux_sel      = r_mux_sel;
    assign result_data  = r_result_data;
    assign result_ch    = r_result_ch;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign scan_done    = r_scan_done;

endmodule
`default_nettype wire
